tx_controller: RTL and testbench

- Sequencing controller for the UART transmit shift register (`transmit`).
- Accepts a host write request and generates the one-cycle `load` strobe and the baud-timed `shift` pulses that datapath needs.
- Counts frame bits per the latched word-format configuration and reports ready/busy/done back to the host.
- Sits between the host register interface and `transmit`. `load`/`shift` drive `transmit` directly; `baud`/`eight`/`parity_en` are shared with the host-side config register.

---
 rtl/tx_controller.sv | 160 ++++++++++++++++
 tb/tb_tx_controller.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_controller.sv
// Frame sequencer for the UART transmit shift register: turns a host write into
// a load strobe, baud-timed shift pulses and a done pulse.
`timescale 1ns/1ps
module tx_controller #(
  parameter int unsigned CLK_HZ        = 100000000,
  parameter int unsigned BAUD_OVERRIDE = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       write,
  input  logic [3:0] baud,
  input  logic       eight,
  input  logic       parity_en,
  output logic       load,
  output logic       shift,
  output logic       tx_rdy,
  output logic       busy,
  output logic       done
);

  // state | meaning
  // IDLE  | ready for a host write
  // LOAD  | one-cycle load strobe, counters cleared
  // SEND  | baud-timed shifting of the frame bits
  // DONE  | one-cycle done pulse after the stop bit
  typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

  function automatic logic [18:0] div_for(input longint unsigned rate);
    longint unsigned k;
    k = (64'(CLK_HZ) + rate / 64'd2) / rate;
    return 19'(k);
  endfunction

  localparam logic [18:0] K_300    = div_for(300);
  localparam logic [18:0] K_1200   = div_for(1200);
  localparam logic [18:0] K_2400   = div_for(2400);
  localparam logic [18:0] K_4800   = div_for(4800);
  localparam logic [18:0] K_9600   = div_for(9600);
  localparam logic [18:0] K_19200  = div_for(19200);
  localparam logic [18:0] K_38400  = div_for(38400);
  localparam logic [18:0] K_57600  = div_for(57600);
  localparam logic [18:0] K_115200 = div_for(115200);
  localparam logic [18:0] K_230400 = div_for(230400);
  localparam logic [18:0] K_460800 = div_for(460800);
  localparam logic [18:0] K_921600 = div_for(921600);

  state_t      state_q, state_d;
  logic [3:0]  baud_q, baud_d;
  logic        eight_q, eight_d;
  logic        parity_q, parity_d;
  logic [18:0] cnt_q, cnt_d;
  logic [3:0]  bit_q, bit_d;
  logic        load_q, load_d;
  logic        shift_q, shift_d;
  logic        tx_rdy_q, tx_rdy_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [18:0] k_sel;
  logic [18:0] k_last;
  logic [3:0]  n_bits;

  always_comb begin
    k_sel = K_921600;
    case (baud_q)
      4'd0:    k_sel = K_300;
      4'd1:    k_sel = K_1200;
      4'd2:    k_sel = K_2400;
      4'd3:    k_sel = K_4800;
      4'd4:    k_sel = K_9600;
      4'd5:    k_sel = K_19200;
      4'd6:    k_sel = K_38400;
      4'd7:    k_sel = K_57600;
      4'd8:    k_sel = K_115200;
      4'd9:    k_sel = K_230400;
      4'd10:   k_sel = K_460800;
      default: k_sel = K_921600;
    endcase
    if (BAUD_OVERRIDE != 0) k_sel = 19'(BAUD_OVERRIDE);
    k_last = k_sel - 19'd1;
    n_bits = 4'd9 + {3'b000, eight_q} + {3'b000, parity_q};
  end

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    eight_d  = eight_q;
    parity_d = parity_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    case (state_q)
      IDLE: begin
        if (write) begin
          state_d  = LOAD;
          baud_d   = baud;
          eight_d  = eight;
          parity_d = parity_en;
        end
      end
      LOAD: begin
        state_d = SEND;
        cnt_d   = '0;
        bit_d   = '0;
      end
      SEND: begin
        if (cnt_q == k_last) begin
          cnt_d = '0;
          bit_d = bit_q + 4'd1;
          if (bit_d == n_bits) state_d = DONE;
        end else begin
          cnt_d = cnt_q + 19'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the next-cycle state/count.
    load_d   = (state_d == LOAD);
    shift_d  = (state_d == SEND) && (cnt_d == k_last);
    tx_rdy_d = (state_d == IDLE) || (state_d == DONE);
    busy_d   = (state_d == LOAD) || (state_d == SEND);
    done_d   = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      eight_q  <= 1'b0;
      parity_q <= 1'b0;
      cnt_q    <= '0;
      bit_q    <= '0;
      load_q   <= 1'b0;
      shift_q  <= 1'b0;
      tx_rdy_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      eight_q  <= eight_d;
      parity_q <= parity_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      load_q   <= load_d;
      shift_q  <= shift_d;
      tx_rdy_q <= tx_rdy_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign load   = load_q;
  assign shift  = shift_q;
  assign tx_rdy = tx_rdy_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_tx_controller.sv
// Bench for tx_controller: fast-divisor instance driven from a vector table with a
// frame scoreboard, plus a real-divisor instance for baud-table spacing.
`timescale 1ns/1ps
module tb_tx_controller;

  localparam int K_A = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       write = 1'b0;
  logic [3:0] baud = 4'd0;
  logic       eight = 1'b0;
  logic       parity_en = 1'b0;
  logic       load, shift, tx_rdy, busy, done;

  logic       write_b = 1'b0;
  logic [3:0] baud_b = 4'd0;
  logic       eight_b = 1'b0;
  logic       par_b = 1'b0;
  logic       load_b, shift_b, tx_rdy_b, busy_b, done_b;

  always #5 clk = ~clk;

  tx_controller #(.CLK_HZ(100000000), .BAUD_OVERRIDE(K_A)) dut (
    .clk(clk), .rst(rst), .write(write), .baud(baud), .eight(eight),
    .parity_en(parity_en), .load(load), .shift(shift), .tx_rdy(tx_rdy),
    .busy(busy), .done(done)
  );

  tx_controller #(.CLK_HZ(100000000), .BAUD_OVERRIDE(0)) dut_b (
    .clk(clk), .rst(rst), .write(write_b), .baud(baud_b), .eight(eight_b),
    .parity_en(par_b), .load(load_b), .shift(shift_b), .tx_rdy(tx_rdy_b),
    .busy(busy_b), .done(done_b)
  );

  typedef struct {
    int n;
    int lat;
  } exp_t;

  typedef struct {
    logic       e;
    logic       p;
    logic [3:0] b;
    int         n;
    int         lat;
  } vec_t;

  exp_t exp_q[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   t_load = 0;
  int   nsh = 0;
  int   active = 0;
  int   frames_done = 0;
  int   n_load = 0;
  int   n_shift = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: a frame is popped at its load and closed at its done.
  always @(negedge clk) begin
    if (rst) begin
      active = 0;
    end else begin
      cyc++;
      if (load || shift) check("load_shift_exclusive", load & shift, 0);
      if (load) begin
        n_load++;
        check("load_expected", (active == 0 && exp_q.size() > 0) ? 1 : 0, 1);
        if (active == 0 && exp_q.size() > 0) begin
          cur = exp_q.pop_front();
          active = 1;
          t_load = cyc;
          nsh = 0;
        end
      end
      if (shift) begin
        n_shift++;
        check("shift_in_frame", active, 1);
        if (active != 0) begin
          nsh++;
          check("shift_timing", cyc - t_load, nsh * K_A);
        end
      end
      if (done) begin
        check("done_in_frame", active, 1);
        if (active != 0) begin
          check("shift_count", nsh, cur.n);
          check("done_latency", cyc - t_load, cur.lat);
          check("done_tx_rdy", tx_rdy, 1);
          check("done_busy", busy, 0);
          active = 0;
          frames_done++;
        end
      end
    end
  end

  task automatic send_frame(input logic e, input logic p, input logic [3:0] b,
                            input int n, input int lat);
    exp_t x;
    x.n = n;
    x.lat = lat;
    exp_q.push_back(x);
    @(negedge clk);
    eight = e; parity_en = p; baud = b; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int c;
    c = 0;
    while (frames_done < target && c < budget) begin
      @(posedge clk);
      c++;
    end
    check("frame_completed", frames_done, target);
    @(negedge clk);
    check("idle_tx_rdy", tx_rdy, 1);
    check("idle_busy", busy, 0);
  endtask

  task automatic wait_b(input int sel, input int budget, output int n);
    logic hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < budget) begin
      @(negedge clk);
      n++;
      hit = (sel == 0) ? load_b : (sel == 1) ? shift_b : done_b;
    end
  endtask

  task automatic baud_check(input logic [3:0] code, input int k);
    int n;
    @(negedge clk);
    baud_b = code;
    write_b = 1'b1;
    wait_b(0, 4, n);
    write_b = 1'b0;
    check("b_load", n, 1);
    wait_b(1, k + 10, n);
    check("b_first_shift", n, k);
    wait_b(1, k + 10, n);
    check("b_shift_spacing", n, k);
    wait_b(2, 8 * k + 10, n);
    check("b_done", n, 7 * k + 1);
    @(negedge clk);
  endtask

  vec_t vecs[4];
  int   fd;
  int   nl0;
  int   ns0;
  int   c;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 4'd3,  9,  37};
    vecs[1] = '{1'b1, 1'b1, 4'd15, 11, 45};
    vecs[2] = '{1'b1, 1'b0, 4'd0,  10, 41};
    vecs[3] = '{1'b0, 1'b1, 4'd8,  10, 41};

    // Reset and quiet idle
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_load", load, 0);
    check("rst_shift", shift, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_tx_rdy", tx_rdy, 1);
    nl0 = n_load;
    ns0 = n_shift;
    repeat (50) @(negedge clk);
    check("idle_no_load", n_load - nl0, 0);
    check("idle_no_shift", n_shift - ns0, 0);

    // Table-driven frames
    for (int i = 0; i < 4; i++) begin
      send_frame(vecs[i].e, vecs[i].p, vecs[i].b, vecs[i].n, vecs[i].lat);
      wait_done(frames_done + 1, 200);
    end

    // Writes and config changes during a frame are ignored
    nl0 = n_load;
    send_frame(1'b0, 1'b0, 4'd0, 9, 37);
    repeat (8) @(negedge clk);
    eight = 1'b1;
    parity_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); write = 1'b1;
      @(negedge clk); write = 1'b0;
    end
    wait_done(frames_done + 1, 200);
    check("busy_write_one_load", n_load - nl0, 1);
    send_frame(1'b1, 1'b1, 4'd0, 11, 45);
    wait_done(frames_done + 1, 200);

    // Reset during the 5th bit aborts the frame without done
    send_frame(1'b0, 1'b0, 4'd0, 9, 37);
    c = 0;
    while (!(active != 0 && nsh >= 4) && c < 100) begin
      @(posedge clk);
      c++;
    end
    check("reached_bit5", (active != 0 && nsh >= 4) ? 1 : 0, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_load", load, 0);
    check("abort_shift", shift, 0);
    check("abort_done", done, 0);
    check("abort_busy", busy, 0);
    check("abort_tx_rdy", tx_rdy, 1);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_abort_tx_rdy", tx_rdy, 1);
    fd = frames_done;
    repeat (50) @(negedge clk);
    check("no_done_after_abort", frames_done, fd);
    send_frame(1'b0, 1'b0, 4'd0, 9, 37);
    wait_done(frames_done + 1, 200);

    // Real divisor table
    baud_check(4'd8, 868);
    baud_check(4'd13, 109);

    check("scoreboard_empty", exp_q.size(), 0);
    check("no_open_frame", active, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
